// File: rtl/elastic_pipe_register_if.sv
// Valid/ready bundle for elastic_pipe_register.
//   in_valid  : upstream data valid        (master -> slave)
//   in_ready  : slave can accept in_data   (slave -> master)
//   in_data   : upstream data, WIDTH bits  (master -> slave)
//   out_valid : out_data valid             (slave -> master)
//   out_ready : downstream accepts         (master -> slave)
//   out_data  : downstream data            (slave -> master)
// The pipe register is the slave; the surrounding logic (or bench) is the master.
interface elastic_pipe_register_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/elastic_pipe_register.sv
// Chain of STAGES elastic valid/ready stages, each with a main and a skid entry.
// Sustains one transfer per cycle under backpressure; ready and valid are registered
// (only the flush gating is combinational), so out_ready never reaches in_ready in the
// same cycle.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset; overrides flush and handshakes
//   flush     : synchronous clear of all entries (data registers keep their value)
//   bus       : valid/ready bundle (slave side), see elastic_pipe_register_if
//   occupancy : number of entries currently held (0 .. 2*STAGES)
module elastic_pipe_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     OCC_W       = $clog2(2 * STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  elastic_pipe_register_if.slave bus,
  output logic [OCC_W-1:0]       occupancy
);

  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] sv;
  logic [WIDTH-1:0]  md [STAGES];

  assign bus.in_ready  = !sv[0] && !flush;
  assign bus.out_valid = mv[STAGES-1] && !flush;
  assign bus.out_data  = md[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             up_valid;
    logic             down_ready;
    logic [WIDTH-1:0] up_data;
    logic             take_in;
    logic             take_out;
    logic             mv_q, mv_d;
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] md_q, sd_q;
    logic             md_en, md_from_skid, sd_en;

    if (s == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = mv[s-1];
      assign up_data  = md[s-1];
    end

    if (s == STAGES - 1) begin : g_tail
      assign down_ready = bus.out_ready;
    end else begin : g_link
      assign down_ready = !sv[s+1];
    end

    // Flush freezes internal movement too, so the chain's data stays put while cleared.
    assign take_in  = up_valid && !sv_q && !flush;
    assign take_out = mv_q && down_ready && !flush;

    always_comb begin
      mv_d         = mv_q;
      sv_d         = sv_q;
      md_en        = 1'b0;
      md_from_skid = 1'b0;
      sd_en        = 1'b0;
      if (sv_q) begin
        // Skid full: upstream is stalled, so only a drain can happen here.
        if (take_out) begin
          md_en        = 1'b1;
          md_from_skid = 1'b1;
          sv_d         = 1'b0;
        end
      end else if (take_in) begin
        if (!mv_q || take_out) begin
          md_en = 1'b1;
          mv_d  = 1'b1;
        end else begin
          sd_en = 1'b1;
          sv_d  = 1'b1;
        end
      end else if (take_out) begin
        mv_d = 1'b0;
      end
      if (flush) begin
        mv_d = 1'b0;
        sv_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mv_q <= 1'b0;
        sv_q <= 1'b0;
        md_q <= RESET_VALUE;
        sd_q <= RESET_VALUE;
      end else begin
        mv_q <= mv_d;
        sv_q <= sv_d;
        if (md_en) md_q <= md_from_skid ? sd_q : up_data;
        if (sd_en) sd_q <= up_data;
      end
    end

    assign mv[s] = mv_q;
    assign sv[s] = sv_q;
    assign md[s] = md_q;
  end

  // Every held entry is exactly one set valid bit, so the count is a popcount.
  always_comb begin
    occupancy = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      occupancy = occupancy + OCC_W'(mv[s]) + OCC_W'(sv[s]);
    end
  end

endmodule

// File: tb/tb_elastic_pipe_register.sv
module tb_elastic_pipe_register;

  logic clk = 1'b0;
  logic rst;
  logic fl1, fl2, fl4;
  logic [1:0] occ1;
  logic [2:0] occ2;
  logic [3:0] occ4;

  int checks = 0;
  int errors = 0;

  elastic_pipe_register_if #(.WIDTH(8)) b1 ();
  elastic_pipe_register_if #(.WIDTH(8)) b2 ();
  elastic_pipe_register_if #(.WIDTH(8)) b4 ();

  elastic_pipe_register #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'h00)) dut1 (
    .clk(clk), .reset(rst), .flush(fl1), .bus(b1.slave), .occupancy(occ1)
  );
  elastic_pipe_register #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'hA5)) dut2 (
    .clk(clk), .reset(rst), .flush(fl2), .bus(b2.slave), .occupancy(occ2)
  );
  elastic_pipe_register #(.WIDTH(8), .STAGES(4), .RESET_VALUE(8'h00)) dut4 (
    .clk(clk), .reset(rst), .flush(fl4), .bus(b4.slave), .occupancy(occ4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    int         eocc;
  } vec_t;

  vec_t tbl [19];
  logic [7:0] mq [3][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0; fl1 = 0;
    b2.in_valid = 0; b2.in_data = 0; b2.out_ready = 0; fl2 = 0;
    b4.in_valid = 0; b4.in_data = 0; b4.out_ready = 0; fl4 = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, b2.out_valid, 0);
    check({tag, "_in_ready"}, b2.in_ready, 1);
    check({tag, "_occupancy"}, occ2, 0);
    check({tag, "_out_data"}, b2.out_data, 8'hA5);
  endtask

  // Behavioural FIFO model: entries in order, capacity 2*stg, cleared by flush.
  task automatic model_step(input int k, input logic fl, input logic iv, input logic ir,
                            input logic [7:0] idat, input logic ov, input logic ordy,
                            input logic [7:0] odat, input int occ, input int stg);
    check("t5_occupancy", occ, mq[k].size());
    if (fl) begin
      check("t5_flush_gate", {ir, ov}, 0);
      mq[k].delete();
    end else begin
      if (mq[k].size() < 2) check("t5_ready_not_full", ir, 1);
      if (mq[k].size() == 2 * stg) check("t5_ready_full", ir, 0);
      if (ov) begin
        check("t5_valid_nonempty", mq[k].size() > 0, 1);
        if (mq[k].size() > 0) begin
          check("t5_out_data", odat, mq[k][0]);
          if (ordy) void'(mq[k].pop_front());
        end
      end
      if (iv && ir) mq[k].push_back(idat);
    end
  endtask

  initial begin
    logic [7:0] exp_d;
    int outs;

    tbl[0]  = '{0, 1, 8'h01, 0, 1, 0, 8'hA5, 0};
    tbl[1]  = '{0, 1, 8'h02, 0, 1, 0, 8'hA5, 1};
    tbl[2]  = '{0, 1, 8'h03, 0, 1, 1, 8'h01, 2};
    tbl[3]  = '{0, 1, 8'h04, 0, 1, 1, 8'h01, 3};
    tbl[4]  = '{0, 1, 8'h05, 0, 0, 1, 8'h01, 4};
    tbl[5]  = '{0, 1, 8'h05, 1, 0, 1, 8'h01, 4};
    tbl[6]  = '{0, 1, 8'h05, 1, 0, 1, 8'h02, 3};
    tbl[7]  = '{0, 1, 8'h05, 1, 1, 1, 8'h03, 2};
    tbl[8]  = '{0, 0, 8'h00, 1, 1, 1, 8'h04, 2};
    tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 8'h05, 1};
    tbl[10] = '{0, 0, 8'h00, 1, 1, 0, 8'h05, 0};
    tbl[11] = '{0, 1, 8'h11, 0, 1, 0, 8'h05, 0};
    tbl[12] = '{0, 1, 8'h12, 0, 1, 0, 8'h05, 1};
    tbl[13] = '{0, 1, 8'h13, 0, 1, 1, 8'h11, 2};
    tbl[14] = '{1, 1, 8'h14, 1, 0, 0, 8'h11, 3};
    tbl[15] = '{0, 1, 8'h77, 0, 1, 0, 8'h11, 0};
    tbl[16] = '{0, 0, 8'h00, 0, 1, 0, 8'h11, 1};
    tbl[17] = '{0, 0, 8'h00, 1, 1, 1, 8'h77, 1};
    tbl[18] = '{0, 0, 8'h00, 1, 1, 0, 8'h77, 0};

    // T1: reset values
    do_reset();
    @(negedge clk);
    check_reset_state("t1");
    @(posedge clk); #1;

    // T2: back-to-back stream with out_ready=1
    exp_d = 8'h01;
    for (int cyc = 0; cyc < 22; cyc++) begin
      b2.in_valid  = (cyc < 16);
      b2.in_data   = 8'(cyc + 1);
      b2.out_ready = 1;
      @(negedge clk);
      if (cyc < 16) check("t2_in_ready", b2.in_ready, 1);
      check("t2_out_valid", b2.out_valid, (cyc >= 2 && cyc < 18));
      if (b2.out_valid) begin
        check("t2_out_data", b2.out_data, exp_d);
        exp_d++;
      end
      @(posedge clk); #1;
    end
    check("t2_item_count", exp_d, 8'h11);

    // T3/T4: fill, drain, flush via vector table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      fl2 = tbl[i].fl; b2.in_valid = tbl[i].iv; b2.in_data = tbl[i].din;
      b2.out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), b2.in_ready, tbl[i].eir);
      check($sformatf("tbl%0d_out_valid", i), b2.out_valid, tbl[i].eov);
      check($sformatf("tbl%0d_out_data", i), b2.out_data, tbl[i].eod);
      check($sformatf("tbl%0d_occupancy", i), occ2, tbl[i].eocc);
      @(posedge clk); #1;
    end
    idle_all();

    // T6: reset in the middle of streaming traffic
    for (int cyc = 0; cyc < 6; cyc++) begin
      b2.in_valid = 1; b2.in_data = 8'(8'h40 + cyc); b2.out_ready = 1;
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    b2.in_valid = 0;
    @(negedge clk);
    check_reset_state("t6");
    @(posedge clk); #1;
    exp_d = 8'h20;
    outs  = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      b2.in_valid = (cyc < 4); b2.in_data = 8'(8'h20 + cyc); b2.out_ready = 1;
      @(negedge clk);
      if (b2.out_valid) begin
        check("t6_out_data", b2.out_data, exp_d);
        exp_d++;
        outs++;
      end
      @(posedge clk); #1;
    end
    check("t6_item_count", outs, 4);

    // T5: random traffic on STAGES=1, 2 and 4 against the FIFO model
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int rp;
      rp = ((cyc / 500) % 2 == 0) ? 85 : 35;
      b1.in_valid = ($urandom_range(99) < 70); b1.in_data = 8'($urandom);
      b1.out_ready = ($urandom_range(99) < rp); fl1 = ($urandom_range(99) < 5);
      b2.in_valid = ($urandom_range(99) < 70); b2.in_data = 8'($urandom);
      b2.out_ready = ($urandom_range(99) < rp); fl2 = ($urandom_range(99) < 5);
      b4.in_valid = ($urandom_range(99) < 70); b4.in_data = 8'($urandom);
      b4.out_ready = ($urandom_range(99) < rp); fl4 = ($urandom_range(99) < 5);
      @(negedge clk);
      model_step(0, fl1, b1.in_valid, b1.in_ready, b1.in_data, b1.out_valid, b1.out_ready,
                 b1.out_data, int'(occ1), 1);
      model_step(1, fl2, b2.in_valid, b2.in_ready, b2.in_data, b2.out_valid, b2.out_ready,
                 b2.out_data, int'(occ2), 2);
      model_step(2, fl4, b4.in_valid, b4.in_ready, b4.in_data, b4.out_valid, b4.out_ready,
                 b4.out_data, int'(occ4), 4);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
